// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control sequencer for the ALU_RegFile datapath.
// Optional performance counters are enabled with `define CTRL_PERF_EN.
//
// state  | meaning
// IDLE   | post-reset wait of RESET_STATE_IDLE_CYCLES cycles
// FETCH  | imem_req high until imem_ready, IR captured on handshake
// DECODE | classify IR, illegal encodings go to TRAP
// EXEC   | drive ALU controls, branches resolve and retire here
// MEM    | data access for loads/stores, stores retire here
// WB     | register write-back, OP/OP-IMM/loads retire here
// TRAP   | sticky illegal-instruction halt, left only via reset
module multicycle_ctrl #(
  parameter int RESET_STATE_IDLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  input  logic        imem_ready,
  input  logic [31:0] instr,
  input  logic        Zero,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ready,
  output logic        RegWrite,
  output logic        ALUSrc,
  output logic [2:0]  ALUControl,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [1:0]  ImmSrc,
  output logic        ResultSrc,
  output logic        PCWrite,
  output logic        PCSrc,
  output logic        retire,
  output logic        illegal
`ifdef CTRL_PERF_EN
  ,
  output logic [31:0] retired_cnt,
  output logic [31:0] stall_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_SRL = 3'b111;

  localparam logic [3:0] IDLE_LAST = 4'(RESET_STATE_IDLE_CYCLES - 1);

  state_t      state_q;
  logic [31:0] ir_q;
  logic [3:0]  idle_cnt_q;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       is_op, is_op_imm, is_load, is_store, is_branch;
  logic       legal;
  logic [2:0] alu_map;
  logic       ctl_alu_src;
  logic [2:0] ctl_alu;
  logic [1:0] ctl_imm;

  assign opcode = ir_q[6:0];
  assign funct3 = ir_q[14:12];
  assign funct7 = ir_q[31:25];
  assign rd     = ir_q[11:7];
  assign rs1    = ir_q[19:15];
  assign rs2    = ir_q[24:20];

  assign is_op     = (opcode == OPC_OP);
  assign is_op_imm = (opcode == OPC_OP_IMM);
  assign is_load   = (opcode == OPC_LOAD);
  assign is_store  = (opcode == OPC_STORE);
  assign is_branch = (opcode == OPC_BRANCH);

  // funct3 -> ALU op; funct7[5] selects sub only for register-register adds
  always_comb begin
    alu_map = ALU_ADD;
    case (funct3)
      3'b000:  alu_map = (is_op && funct7[5]) ? ALU_SUB : ALU_ADD;
      3'b111:  alu_map = ALU_AND;
      3'b110:  alu_map = ALU_OR;
      3'b100:  alu_map = ALU_XOR;
      3'b010:  alu_map = ALU_SLT;
      3'b001:  alu_map = ALU_SLL;
      3'b101:  alu_map = ALU_SRL;
      default: alu_map = ALU_ADD;
    endcase
  end

  always_comb begin
    legal = 1'b0;
    if (is_op) begin
      case (funct3)
        3'b011:  legal = 1'b0;
        3'b101:  legal = ~funct7[5];
        default: legal = 1'b1;
      endcase
    end else if (is_op_imm) begin
      case (funct3)
        3'b011:  legal = 1'b0;
        3'b101:  legal = (funct7 == 7'd0);
        default: legal = 1'b1;
      endcase
    end else if (is_load || is_store) begin
      legal = (funct3 == 3'b010);
    end else if (is_branch) begin
      legal = (funct3 == 3'b000) || (funct3 == 3'b001);
    end
  end

  // ALU-side controls shared by EXEC, MEM and WB
  always_comb begin
    ctl_alu_src = 1'b0;
    ctl_alu     = ALU_ADD;
    ctl_imm     = 2'b00;
    if (is_op) begin
      ctl_alu = alu_map;
    end else if (is_op_imm) begin
      ctl_alu_src = 1'b1;
      ctl_alu     = alu_map;
    end else if (is_load) begin
      ctl_alu_src = 1'b1;
    end else if (is_store) begin
      ctl_alu_src = 1'b1;
      ctl_imm     = 2'b01;
    end else if (is_branch) begin
      ctl_alu = ALU_SUB;
      ctl_imm = 2'b10;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ir_q       <= 32'd0;
      idle_cnt_q <= 4'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (idle_cnt_q == IDLE_LAST) begin
            idle_cnt_q <= 4'd0;
            state_q    <= S_FETCH;
          end else begin
            idle_cnt_q <= idle_cnt_q + 4'd1;
          end
        end
        S_FETCH: begin
          if (imem_ready) begin
            ir_q    <= instr;
            state_q <= S_DECODE;
          end
        end
        S_DECODE: state_q <= legal ? S_EXEC : S_TRAP;
        S_EXEC: begin
          if (is_branch)                state_q <= S_FETCH;
          else if (is_load || is_store) state_q <= S_MEM;
          else                          state_q <= S_WB;
        end
        S_MEM: begin
          if (dmem_ready) state_q <= is_store ? S_FETCH : S_WB;
        end
        S_WB:    state_q <= S_FETCH;
        S_TRAP:  state_q <= S_TRAP;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    RegWrite   = 1'b0;
    ALUSrc     = 1'b0;
    ALUControl = ALU_ADD;
    ImmSrc     = 2'b00;
    ResultSrc  = 1'b0;
    PCWrite    = 1'b0;
    PCSrc      = 1'b0;
    retire     = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      S_FETCH: imem_req = 1'b1;
      S_EXEC: begin
        ALUSrc     = ctl_alu_src;
        ALUControl = ctl_alu;
        ImmSrc     = ctl_imm;
        if (is_branch) begin
          PCWrite = 1'b1;
          PCSrc   = funct3[0] ? ~Zero : Zero;
          retire  = 1'b1;
        end
      end
      S_MEM: begin
        ALUSrc     = ctl_alu_src;
        ALUControl = ctl_alu;
        ImmSrc     = ctl_imm;
        dmem_req   = 1'b1;
        dmem_we    = is_store;
        if (is_store && dmem_ready) begin
          PCWrite = 1'b1;
          retire  = 1'b1;
        end
      end
      S_WB: begin
        ALUSrc     = ctl_alu_src;
        ALUControl = ctl_alu;
        ImmSrc     = ctl_imm;
        RegWrite   = (rd != 5'd0);
        ResultSrc  = is_load;
        PCWrite    = 1'b1;
        retire     = 1'b1;
      end
      S_TRAP:  illegal = 1'b1;
      default: ;
    endcase
  end

`ifdef CTRL_PERF_EN
  logic [31:0] retired_cnt_q;
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_cnt_q <= 32'd0;
      stall_cnt_q   <= 32'd0;
    end else begin
      if (retire) retired_cnt_q <= retired_cnt_q + 32'd1;
      if ((imem_req && !imem_ready) || (dmem_req && !dmem_ready))
        stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign retired_cnt = retired_cnt_q;
  assign stall_cnt   = stall_cnt_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: stimulus queues the expected retire
// signature of each instruction, a negedge monitor checks it on every retire.
module tb_multicycle_ctrl;

  logic        clk;
  logic        rst_n;
  logic        imem_req, imem_ready;
  logic [31:0] instr;
  logic        Zero;
  logic        dmem_req, dmem_we, dmem_ready;
  logic        RegWrite, ALUSrc;
  logic [2:0]  ALUControl;
  logic [4:0]  rs1, rs2, rd;
  logic [1:0]  ImmSrc;
  logic        ResultSrc, PCWrite, PCSrc, retire, illegal;
`ifdef CTRL_PERF_EN
  logic [31:0] retired_cnt, stall_cnt;
`endif

  multicycle_ctrl #(.RESET_STATE_IDLE_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_ready(imem_ready), .instr(instr),
    .Zero(Zero),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
    .RegWrite(RegWrite), .ALUSrc(ALUSrc), .ALUControl(ALUControl),
    .rs1(rs1), .rs2(rs2), .rd(rd),
    .ImmSrc(ImmSrc), .ResultSrc(ResultSrc), .PCWrite(PCWrite), .PCSrc(PCSrc),
    .retire(retire), .illegal(illegal)
`ifdef CTRL_PERF_EN
    , .retired_cnt(retired_cnt), .stall_cnt(stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rw;
    logic [4:0] rd;
    logic [2:0] alu;
    logic       alusrc;
    logic [1:0] imm;
    logic       res;
    logic       pcsrc;
    int         lat;
    int         dcyc;
    logic       we;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(logic rw, logic [4:0] r, logic [2:0] alu, logic as,
                              logic [1:0] im, logic rs, logic pc, int lat, int dc, logic we);
    exp_t e;
    e.rw = rw; e.rd = r; e.alu = alu; e.alusrc = as; e.imm = im;
    e.res = rs; e.pcsrc = pc; e.lat = lat; e.dcyc = dc; e.we = we;
    return e;
  endfunction

  function automatic logic [31:0] out_vec();
    return 32'({imem_req, dmem_req, dmem_we, RegWrite, ALUSrc, ALUControl, rs1, rs2, rd,
                ImmSrc, ResultSrc, PCWrite, PCSrc, retire, illegal});
  endfunction

  // Monitor: latency is counted from the first FETCH cycle to the retire cycle
  int   cyc = 0, fstart = 0, dcyc = 0;
  logic prev_req = 1'b0, we_seen = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (imem_req && !prev_req) begin
      fstart = cyc; dcyc = 0; we_seen = 1'b0;
    end
    prev_req = imem_req;
    if (dmem_req) begin
      dcyc++;
      if (dmem_we) we_seen = 1'b1;
    end
    if (retire) begin
      if (sb.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_retire: got retire=1, expected no retire (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        check("ret_regwrite", 32'(RegWrite), 32'(e.rw));
        check("ret_rd", 32'(rd), 32'(e.rd));
        check("ret_aluctl", 32'(ALUControl), 32'(e.alu));
        check("ret_alusrc", 32'(ALUSrc), 32'(e.alusrc));
        check("ret_immsrc", 32'(ImmSrc), 32'(e.imm));
        check("ret_resultsrc", 32'(ResultSrc), 32'(e.res));
        check("ret_pcwrite", 32'(PCWrite), 32'd1);
        check("ret_pcsrc", 32'(PCSrc), 32'(e.pcsrc));
        check("ret_latency", 32'(cyc - fstart + 1), 32'(e.lat));
        check("ret_dmem_cycles", 32'(dcyc), 32'(e.dcyc));
        check("ret_dmem_we", 32'(we_seen), 32'(e.we));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sb.delete();
    imem_ready = 1'b0; dmem_ready = 1'b0; Zero = 1'b0; instr = 32'd0;
    tick(); tick();
    rst_n = 1'b1;
    check("idle_hold", 32'(imem_req), 32'd0);
    tick();
    check("idle_exit", 32'(imem_req), 32'd1);
  endtask

  task automatic run(input logic [31:0] ins, input logic z, input int idly,
                     input int ddly, input exp_t e);
    bit ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (imem_req) begin ok = 1'b1; break; end
      tick();
    end
    if (!ok) begin
      n_chk++; n_fail++;
      $display("FAIL fetch_timeout: got imem_req=0, expected 1 for instr 0x%08h", ins);
      return;
    end
    Zero = z;
    repeat (idly) tick();
    sb.push_back(e);
    instr = ins; imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    if (ins[6:0] == 7'b0000011 || ins[6:0] == 7'b0100011) begin
      ok = 1'b0;
      for (int i = 0; i < 16; i++) begin
        if (dmem_req) begin ok = 1'b1; break; end
        tick();
      end
      if (!ok) begin
        n_chk++; n_fail++;
        $display("FAIL dmem_timeout: got dmem_req=0, expected 1 for instr 0x%08h", ins);
        return;
      end
      // a stray imem_ready with a trapping word must not disturb the memory phase
      instr = 32'd0; imem_ready = 1'b1;
      repeat (ddly) tick();
      imem_ready = 1'b0; dmem_ready = 1'b1;
      tick();
      dmem_ready = 1'b0;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) tick();
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
  endtask

  logic [31:0] ill_vec [6];
  int          bad;

  initial begin
    ill_vec = '{32'h4010D093, 32'h00008083, 32'h0020C463, 32'h0020B1B3,
                32'h00000000, 32'h0000006F};
    rst_n = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0; Zero = 1'b0; instr = 32'd0;
    tick(); tick();
    check("reset_outputs", out_vec(), 32'd0);
    rst_n = 1'b1;
    check("idle_hold", 32'(imem_req), 32'd0);
    tick();
    check("idle_exit", 32'(imem_req), 32'd1);

    // ten back-to-back instructions, one fetch stalled 3 cycles
    run(32'h002081B3, 1'b0, 0, 0, mk(1, 5'd3, 3'b000, 0, 2'b00, 0, 0, 4, 0, 0));
    run(32'h40208233, 1'b0, 0, 0, mk(1, 5'd4, 3'b001, 0, 2'b00, 0, 0, 4, 0, 0));
    run(32'h0020C333, 1'b0, 0, 0, mk(1, 5'd6, 3'b100, 0, 2'b00, 0, 0, 4, 0, 0));
    run(32'h00309393, 1'b0, 0, 0, mk(1, 5'd7, 3'b110, 1, 2'b00, 0, 0, 4, 0, 0));
    run(32'h0020D413, 1'b0, 0, 0, mk(1, 5'd8, 3'b111, 1, 2'b00, 0, 0, 4, 0, 0));
    run(32'h0FF0F493, 1'b0, 3, 0, mk(1, 5'd9, 3'b010, 1, 2'b00, 0, 0, 7, 0, 0));
    run(32'h00100013, 1'b0, 0, 0, mk(0, 5'd0, 3'b000, 1, 2'b00, 0, 0, 4, 0, 0));
    run(32'h00208463, 1'b1, 0, 0, mk(0, 5'd8, 3'b001, 0, 2'b10, 0, 1, 3, 0, 0));
    run(32'h00208463, 1'b0, 0, 0, mk(0, 5'd8, 3'b001, 0, 2'b10, 0, 0, 3, 0, 0));
    run(32'h00209463, 1'b0, 0, 0, mk(0, 5'd8, 3'b001, 0, 2'b10, 0, 1, 3, 0, 0));
    drain();
`ifdef CTRL_PERF_EN
    check("perf_retired_cnt", retired_cnt, 32'd10);
    check("perf_stall_cnt", stall_cnt, 32'd3);
`endif

    // memory accesses and a non-taken bne
    do_reset();
    run(32'h0080A283, 1'b0, 0, 2, mk(1, 5'd5, 3'b000, 1, 2'b00, 1, 0, 7, 3, 0));
    run(32'h0020A223, 1'b0, 0, 1, mk(0, 5'd4, 3'b000, 1, 2'b01, 0, 0, 5, 2, 1));
    run(32'h0020A223, 1'b0, 0, 0, mk(0, 5'd4, 3'b000, 1, 2'b01, 0, 0, 4, 1, 1));
    run(32'h00209463, 1'b1, 0, 0, mk(0, 5'd8, 3'b001, 0, 2'b10, 0, 0, 3, 0, 0));
    drain();

    // sra traps; trap holds with imem_ready high until reset
    do_reset();
    instr = 32'h4020D1B3; imem_ready = 1'b1;
    tick();
    check("decode_not_trapped", 32'(illegal), 32'd0);
    tick();
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (!illegal || imem_req || retire) bad++;
      tick();
    end
    check("trap_hold_bad_cycles", 32'(bad), 32'd0);
    rst_n = 1'b0;
    #1;
    check("trap_reset_outputs", out_vec(), 32'd0);

    for (int i = 0; i < 6; i++) begin
      do_reset();
      instr = ill_vec[i]; imem_ready = 1'b1;
      tick();
      imem_ready = 1'b0;
      tick();
      check($sformatf("illegal_%0d", i), 32'(illegal), 32'd1);
    end

    // reset in the middle of a store's memory phase
    do_reset();
    instr = 32'h0020A223; imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    for (int i = 0; i < 8 && !dmem_req; i++) tick();
    check("store_mem_reached", 32'(dmem_req), 32'd1);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_drops_req", 32'({dmem_req, retire, imem_req}), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    check("refetch_idle_hold", 32'(imem_req), 32'd0);
    tick();
    check("refetch_after_idle", 32'(imem_req), 32'd1);
    run(32'h002081B3, 1'b0, 0, 0, mk(1, 5'd3, 3'b000, 0, 2'b00, 0, 0, 4, 0, 0));
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle RV32I control sequencer that drives the ALU/register-file datapath: RegWrite, ALUSrc, ALUControl, rs1/rs2/rd.
- Fetches each instruction over a req/ready handshake, decodes it, and steps it through EXEC/MEM/WB states.
- Drives PC update, data-memory requests and write-back select.
- Sits between the instruction/data memory interfaces and the ALU_RegFile datapath, replacing single-cycle decode.

Parameters:
- RESET_STATE_IDLE_CYCLES, 1, cycles spent in IDLE after reset release before the first FETCH (1..15).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- imem_req  out  1  instruction fetch request
- imem_ready  in  1  fetch accepted; instr valid this cycle
- instr  in  32  instruction word, sampled when imem_req&imem_ready
- Zero  in  1  ALU equal flag from datapath
- dmem_req  out  1  data memory request
- dmem_we  out  1  1=store, 0=load; valid with dmem_req
- dmem_ready  in  1  data access complete
- RegWrite  out  1  register file write enable
- ALUSrc  out  1  0=rs2, 1=immediate
- ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt, 110 sll, 111 srl
- rs1, rs2, rd  out  5 each  register fields from the instruction register (IR)
- ImmSrc  out  2  00 I-type, 01 S-type, 10 B-type
- ResultSrc  out  1  0=ALUResult, 1=load data to WD3
- PCWrite  out  1  PC update strobe
- PCSrc  out  1  0=PC+4, 1=PC+imm
- retire  out  1  one-cycle pulse per completed instruction
- illegal  out  1  sticky trap flag

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP. IR is 32-bit and loads only in FETCH on imem_req&imem_ready.
- Outputs are combinational from state+IR. Outputs not listed for a state are 0. rs1/rs2/rd always reflect IR.
- Reset (async, any state): state=IDLE, IR=0, idle counter=0. All outputs 0, rs1/rs2/rd=0.
- IDLE: count RESET_STATE_IDLE_CYCLES, then go to FETCH.
- FETCH: imem_req=1, held until imem_ready. Go to DECODE the cycle after the handshake; a ready without req is ignored.
- DECODE: classify IR[6:0]; if illegal, go to TRAP, otherwise EXEC. Legal set:
  - OP 0110011, funct3/funct7[5]: 000/0 add, 000/1 sub, 111 and, 110 or, 100 xor, 010 slt, 001 sll, 101/0 srl.
  - OP-IMM 0010011: same mapping, but 000 is always add; 101 requires imm[11:5]=0.
  - LOAD 0000011 and STORE 0100011: funct3=010 only.
  - BRANCH 1100011: funct3 000 (beq) or 001 (bne).
  - Everything else is illegal, including sra/srai, sltu, byte/half accesses and other branches.
- EXEC:
  - OP: ALUSrc=0, ALUControl per the mapping; go to WB.
  - OP-IMM: ALUSrc=1, ImmSrc=00; go to WB.
  - LOAD/STORE: ALUSrc=1, add, ImmSrc=00 (load) or 01 (store); go to MEM.
  - BRANCH: ALUSrc=0, sub, ImmSrc=10, PCWrite=1, PCSrc=(beq?Zero:~Zero), retire=1; go to FETCH.
- MEM: dmem_req=1, dmem_we=store, ALU controls held as in EXEC; wait for dmem_ready. Store: PCWrite=1, PCSrc=0, retire=1, go to FETCH. Load: go to WB.
- WB: RegWrite=(rd!=0), ResultSrc=load, ALU controls held as in EXEC, PCWrite=1, PCSrc=0, retire=1; go to FETCH.
- TRAP: illegal=1 and all other outputs 0; leave only via reset.
- Latency with ready asserted in the same cycle (from FETCH entry to the retire cycle):
  - branch 3 cycles, OP/OP-IMM 4, store 4, load 5.
  - Each cycle of ready low adds exactly 1 cycle.
- Simultaneous imem_ready and dmem_ready: only the one matching the current state is honoured.
- rst_n asserted mid-request: req drops asynchronously and no retire is issued.

Optional Feature:
- Macro CTRL_PERF_EN.
- Defined: adds output retired_cnt [31:0], reset 0, +1 on each retire cycle, wraps 0xFFFFFFFF to 0.
- Also adds output stall_cnt [31:0], reset 0, +1 each cycle imem_req&~imem_ready or dmem_req&~dmem_ready, wraps.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Reset, then imem_ready=1 with instr 0x002081B3 (add x3,x1,x2) -> FETCH,DECODE,EXEC,WB. In WB: RegWrite=1, rd=3, ALUControl=000, ALUSrc=0, retire=1. Total 4 cycles after IDLE.
- lw x5,8(x1)=0x0080A283 with dmem_ready delayed 2 cycles -> dmem_req=1, dmem_we=0 for 3 cycles. WB has ResultSrc=1, RegWrite=1. retire at cycle 7.
- beq 0x00208463 with Zero=1 -> EXEC: PCWrite=1, PCSrc=1, ALUControl=001. Repeat with Zero=0 -> PCSrc=0. bne (funct3=001) with Zero=0 -> PCSrc=1.
- sra 0x4020D1B3 -> TRAP, illegal=1 and stays 1 for 20 cycles with imem_req=0. Then rst_n pulse -> illegal=0, state IDLE.
- addi x0,x0,1 -> WB with RegWrite=0 but retire=1. rst_n low during MEM of a store -> dmem_req drops immediately, no retire, refetch after IDLE.
- CTRL_PERF_EN: 10 instructions, with imem_ready low 3 cycles once -> retired_cnt=10, stall_cnt=3.
